mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port memory bus arbiter and sequencer for the single-cycle core. It shares one external memory bus between the instruction-fetch port and the data-access port, running one bus transaction at a time with a ready-based handshake. It drives a stall signal that the core uses to gate `pc_wren` while any access is outstanding. The block sits between `core_single` and the system bus, in the slot the data memory interface occupies.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus wait-cycle limit, effective only with `MEM_ARB_TIMEOUT_EN`; legal range 1..65535.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held until `if_valid`.
- `if_addr` in 32: fetch address.
- `if_rdata` out 32: fetched word.
- `if_valid` out 1: one-cycle completion pulse for fetch.
- `d_rd_en` in 1: data read request; held until `d_valid`.
- `d_wr_en` in 1: data write request; held until `d_valid`.
- `d_addr` in 32: data address.
- `d_wrdata` in 32: write data.
- `d_byte_en` in 4: write/read byte lanes.
- `d_rdata` out 32: read data.
- `d_valid` out 1: one-cycle completion pulse for data.
- `bus_err` out 1: completion was a timeout. Pulses with the matching `*_valid`.
- `stall` out 1: `(if_req & ~if_valid) | ((d_rd_en | d_wr_en) & ~d_valid)`, combinational.
- `bus_rd_en` out 1, `bus_wr_en` out 1, `bus_addr` out 32, `bus_data_wr` out 32, `bus_byte_en` out 4: registered bus command.
- `bus_data_rd` in 32: bus read data, valid when `bus_ready` is high.
- `bus_ready` in 1: slave completion, sampled each cycle while a command is active.

## Operation
- FSM states: IDLE, FETCH, DATA.
- **IDLE**
  - Data request pending → load command and go to DATA.
  - Else if `if_req` → go to FETCH.
  - Data has fixed priority over fetch.
- **FETCH command**
  - `bus_rd_en`=1.
  - `bus_addr`={`if_addr[31:2]`,2'b00}.
  - `bus_byte_en`=4'b1111.
- **DATA command**
  - `bus_addr`=`d_addr`, unmodified.
  - `bus_byte_en`=`d_byte_en`.
  - If `d_wr_en` → `bus_wr_en`=1 with `bus_data_wr`=`d_wrdata`; otherwise `bus_rd_en`=1.
  - `d_rd_en` and `d_wr_en` both high → treated as a write; `d_rdata` is not updated.
- **Completion** (FETCH/DATA with `bus_ready`=1)
  - Read data captured into `if_rdata`/`d_rdata`.
  - Matching `*_valid` pulses on the next cycle.
  - Bus enables drop on the next cycle.
  - FSM returns to IDLE.
- Command registers stay stable for the whole transaction; input changes mid-transaction are ignored.
- Requester drops its request mid-transaction → the transaction still completes and `*_valid` still pulses.
- `if_rdata`/`d_rdata` hold their last value between transactions.

## Timing
- Reset: all outputs 0, state IDLE, timeout counter 0.
- Request high at edge N (state IDLE) → bus enable high after edge N+1.
- `bus_ready` high at edge N+k → `*_valid`/rdata after edge N+k+1, enables low.
- Zero-wait slave (`bus_ready` tied 1):
  - 2-cycle latency per access.
  - Next request is granted the cycle after IDLE is re-entered.
  - Sustained throughput: one access per 3 cycles.
- Both requests arrive in the same cycle → DATA completes, then FETCH; fetch waits at most one data transaction.
- Reset asserted mid-transaction → bus enables drop asynchronously, no `*_valid` is produced, FSM goes to IDLE.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter counts cycles in FETCH/DATA with `bus_ready`=0.
  - When the count reaches `TIMEOUT_CYCLES`, the transaction terminates: enables drop, rdata is set to 32'h0000_0000, `*_valid` and `bus_err` pulse together, FSM goes to IDLE.
  - The counter clears on every transaction start.
- Undefined: no counter, arbiter waits indefinitely, `bus_err` tied 0.

## Test plan
- Fetch only:
  - Stimulus: `if_addr`=32'h0000_0106, `bus_ready` tied 1, `bus_data_rd`=32'h0010_0093.
  - Response: `bus_addr`=32'h0000_0104, `bus_byte_en`=4'hF, `if_rdata`=32'h0010_0093 with `if_valid` 2 cycles after request; `stall` high until that pulse.
- Simultaneous requests:
  - Stimulus: `if_req` and `d_rd_en` high in the same cycle.
  - Response: data transaction first (`d_valid`), fetch command issued the cycle after IDLE is re-entered.
- Write with wait states:
  - Stimulus: `d_wr_en`, `d_addr`=32'h2000_0003, `d_byte_en`=4'b1000, `d_wrdata`=32'hAB00_0000, `bus_ready` low 3 cycles.
  - Response: command held stable 4 cycles, `d_valid` 1 cycle after `bus_ready`, `d_rdata` unchanged.
- Reset mid-access:
  - Stimulus: `rst` low while in DATA with `bus_ready`=0.
  - Response: `bus_rd_en`/`bus_wr_en` low immediately, no `d_valid`; first request after release follows normal latency.
- Timeout (`MEM_ARB_TIMEOUT_EN`):
  - Stimulus: `TIMEOUT_CYCLES`=4, `bus_ready` stuck 0.
  - Response: `d_valid`=`bus_err`=1 and `d_rdata`=0 once the count reaches 4; next request served normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Core-side request/response signals and external bus command signals.
// slave  : the arbiter's view (drives bus command and completions).
// master : the core and bus-slave view (drives requests and bus responses).
interface mem_bus_arbiter_if;
  // fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  // data port
  logic        d_rd_en;
  logic        d_wr_en;
  logic [31:0] d_addr;
  logic [31:0] d_wrdata;
  logic [3:0]  d_byte_en;
  logic [31:0] d_rdata;
  logic        d_valid;
  // status
  logic        bus_err;
  logic        stall;
  // external bus
  logic        bus_rd_en;
  logic        bus_wr_en;
  logic [31:0] bus_addr;
  logic [31:0] bus_data_wr;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_data_rd;
  logic        bus_ready;

  modport slave (
    input  if_req, if_addr, d_rd_en, d_wr_en, d_addr, d_wrdata, d_byte_en,
           bus_data_rd, bus_ready,
    output if_rdata, if_valid, d_rdata, d_valid, bus_err, stall,
           bus_rd_en, bus_wr_en, bus_addr, bus_data_wr, bus_byte_en
  );

  modport master (
    output if_req, if_addr, d_rd_en, d_wr_en, d_addr, d_wrdata, d_byte_en,
           bus_data_rd, bus_ready,
    input  if_rdata, if_valid, d_rdata, d_valid, bus_err, stall,
           bus_rd_en, bus_wr_en, bus_addr, bus_data_wr, bus_byte_en
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the fetch and data ports,
// one transaction at a time, data having fixed priority over fetch.
// Optional feature macro: MEM_ARB_TIMEOUT_EN enables the bus wait-cycle
// timeout (TIMEOUT_CYCLES); without it the arbiter waits for bus_ready forever
// and bus_err stays 0.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave mb
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_DATA = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        start_d, start_f, finish;
  logic        d_pend, f_pend, done, tmo_hit;
  logic [31:0] cap_data;

  logic        bus_rd_en_q, bus_wr_en_q;
  logic [31:0] bus_addr_q, bus_data_wr_q;
  logic [3:0]  bus_byte_en_q;
  logic        if_valid_q, d_valid_q, bus_err_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  // Word-aligned fetch ignores the byte offset.
  logic unused_if_lsb;
  assign unused_if_lsb = ^mb.if_addr[1:0];

  // A requester still holding its request during its own valid pulse is the
  // tail of the finished access, not a new one, so it is not re-granted.
  assign d_pend = (mb.d_rd_en | mb.d_wr_en) & ~d_valid_q;
  assign f_pend = mb.if_req & ~if_valid_q;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q;

  // Terminate on the wait cycle that brings the count to TIMEOUT_CYCLES.
  assign tmo_hit = (state_q != S_IDLE) & ~mb.bus_ready & (tmo_cnt_q == TMO_LAST);

  // Wait-cycle counter, cleared at each transaction start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   tmo_cnt_q <= '0;
    else if (start_d | start_f)                 tmo_cnt_q <= '0;
    else if (state_q != S_IDLE && !mb.bus_ready) tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign done     = mb.bus_ready | tmo_hit;
  assign cap_data = mb.bus_ready ? mb.bus_data_rd : 32'h0000_0000;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: data beats fetch; any active state leaves on completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (d_pend)      state_d = S_DATA;
        else if (f_pend) state_d = S_FETCH;
      end
      S_FETCH, S_DATA: if (done) state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  // FSM outputs: command load and completion strobes.
  always_comb begin
    start_d = (state_q == S_IDLE) & d_pend;
    start_f = (state_q == S_IDLE) & ~d_pend & f_pend;
    finish  = (state_q != S_IDLE) & done;
  end

  // Bus command, completion pulses and read-data holding registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_rd_en_q   <= 1'b0;
      bus_wr_en_q   <= 1'b0;
      bus_addr_q    <= '0;
      bus_data_wr_q <= '0;
      bus_byte_en_q <= '0;
      if_valid_q    <= 1'b0;
      d_valid_q     <= 1'b0;
      bus_err_q     <= 1'b0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      if (start_d) begin
        // read+write together is a write
        bus_rd_en_q   <= ~mb.d_wr_en;
        bus_wr_en_q   <= mb.d_wr_en;
        bus_addr_q    <= mb.d_addr;
        bus_data_wr_q <= mb.d_wr_en ? mb.d_wrdata : 32'h0000_0000;
        bus_byte_en_q <= mb.d_byte_en;
      end else if (start_f) begin
        bus_rd_en_q   <= 1'b1;
        bus_wr_en_q   <= 1'b0;
        bus_addr_q    <= {mb.if_addr[31:2], 2'b00};
        bus_data_wr_q <= 32'h0000_0000;
        bus_byte_en_q <= 4'b1111;
      end else if (finish) begin
        bus_rd_en_q <= 1'b0;
        bus_wr_en_q <= 1'b0;
        bus_err_q   <= tmo_hit;
        if (state_q == S_FETCH) begin
          if_valid_q <= 1'b1;
          if_rdata_q <= cap_data;
        end else begin
          d_valid_q <= 1'b1;
          // writes leave d_rdata untouched, including on timeout
          if (bus_rd_en_q) d_rdata_q <= cap_data;
        end
      end
    end
  end

  assign mb.bus_rd_en   = bus_rd_en_q;
  assign mb.bus_wr_en   = bus_wr_en_q;
  assign mb.bus_addr    = bus_addr_q;
  assign mb.bus_data_wr = bus_data_wr_q;
  assign mb.bus_byte_en = bus_byte_en_q;
  assign mb.if_valid    = if_valid_q;
  assign mb.d_valid     = d_valid_q;
  assign mb.if_rdata    = if_rdata_q;
  assign mb.d_rdata     = d_rdata_q;
  assign mb.bus_err     = bus_err_q;
  assign mb.stall       = (mb.if_req & ~if_valid_q) |
                          ((mb.d_rd_en | mb.d_wr_en) & ~d_valid_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model plus directed vectors.
module tb_mem_bus_arbiter;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if mb ();

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .mb  (mb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: the bus holds at most one open transaction -------
  bit          m_busy, m_fetch, m_wr;
  logic [31:0] m_addr, m_wd, m_ird, m_drd;
  logic [3:0]  m_be;
  int          m_wait;
  bit          m_ifv, m_dv, m_err;
  bit          m_timed;

  assign m_timed = TMO_EN && m_busy && !mb.bus_ready && (m_wait + 1 == TMO);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_fetch <= 0; m_wr <= 0; m_addr <= '0; m_wd <= '0; m_be <= '0;
      m_wait <= 0; m_ifv <= 0; m_dv <= 0; m_err <= 0; m_ird <= '0; m_drd <= '0;
    end else begin
      m_ifv <= 0; m_dv <= 0; m_err <= 0;
      if (m_busy) begin
        if (mb.bus_ready || m_timed) begin
          m_busy <= 0;
          m_err  <= m_timed;
          if (m_fetch) begin
            m_ifv <= 1;
            m_ird <= mb.bus_ready ? mb.bus_data_rd : 32'h0;
          end else begin
            m_dv <= 1;
            if (!m_wr) m_drd <= mb.bus_ready ? mb.bus_data_rd : 32'h0;
          end
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if ((mb.d_rd_en || mb.d_wr_en) && !m_dv) begin
        m_busy <= 1; m_fetch <= 0; m_wr <= mb.d_wr_en; m_wait <= 0;
        m_addr <= mb.d_addr; m_be <= mb.d_byte_en;
        m_wd   <= mb.d_wr_en ? mb.d_wrdata : 32'h0;
      end else if (mb.if_req && !m_ifv) begin
        m_busy <= 1; m_fetch <= 1; m_wr <= 0; m_wait <= 0;
        m_addr <= {mb.if_addr[31:2], 2'b00}; m_be <= 4'hF; m_wd <= 32'h0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk1("bus_rd_en",   mb.bus_rd_en, m_busy & ~m_wr);
    chk1("bus_wr_en",   mb.bus_wr_en, m_busy & m_wr);
    chk ("bus_addr",    mb.bus_addr, m_addr);
    chk ("bus_data_wr", mb.bus_data_wr, m_wd);
    chk ("bus_byte_en", {28'h0, mb.bus_byte_en}, {28'h0, m_be});
    chk1("if_valid",    mb.if_valid, m_ifv);
    chk1("d_valid",     mb.d_valid, m_dv);
    chk1("bus_err",     mb.bus_err, m_err);
    chk ("if_rdata",    mb.if_rdata, m_ird);
    chk ("d_rdata",     mb.d_rdata, m_drd);
    chk1("stall",       mb.stall, (mb.if_req & ~m_ifv) | ((mb.d_rd_en | mb.d_wr_en) & ~m_dv));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed vectors ----------------
  initial begin
    int n;
    mb.if_req = 0; mb.if_addr = '0; mb.d_rd_en = 0; mb.d_wr_en = 0; mb.d_addr = '0;
    mb.d_wrdata = '0; mb.d_byte_en = '0; mb.bus_data_rd = '0; mb.bus_ready = 0;
    tick(); tick();
    chk1("rst_bus_rd_en", mb.bus_rd_en, 1'b0);
    chk1("rst_if_valid",  mb.if_valid, 1'b0);
    chk ("rst_d_rdata",   mb.d_rdata, 32'h0);
    chk ("rst_bus_addr",  mb.bus_addr, 32'h0);
    rst = 1;
    tick();

    // fetch only, zero-wait slave
    mb.bus_ready = 1; mb.bus_data_rd = 32'h0010_0093;
    mb.if_addr = 32'h0000_0106; mb.if_req = 1;
    #1 chk1("f_stall_req", mb.stall, 1'b1);
    tick();
    chk1("f_rd_en",   mb.bus_rd_en, 1'b1);
    chk ("f_addr",    mb.bus_addr, 32'h0000_0104);
    chk ("f_be",      {28'h0, mb.bus_byte_en}, 32'hF);
    chk1("f_stall",   mb.stall, 1'b1);
    tick();
    chk1("f_valid",   mb.if_valid, 1'b1);
    chk ("f_rdata",   mb.if_rdata, 32'h0010_0093);
    chk1("f_rd_drop", mb.bus_rd_en, 1'b0);
    chk1("f_stall_done", mb.stall, 1'b0);
    mb.if_req = 0;
    tick();
    chk1("f_valid_1cyc", mb.if_valid, 1'b0);

    // simultaneous requests: data first, then fetch
    mb.bus_data_rd = 32'hCAFE_0001;
    mb.if_req = 1; mb.if_addr = 32'h0000_0200;
    mb.d_rd_en = 1; mb.d_addr = 32'h1000_0010; mb.d_byte_en = 4'b0011;
    tick();
    chk ("s_data_addr", mb.bus_addr, 32'h1000_0010);
    chk ("s_data_be",   {28'h0, mb.bus_byte_en}, 32'h3);
    tick();
    chk1("s_d_valid",   mb.d_valid, 1'b1);
    chk ("s_d_rdata",   mb.d_rdata, 32'hCAFE_0001);
    chk1("s_f_waiting", mb.if_valid, 1'b0);
    mb.d_rd_en = 0; mb.bus_data_rd = 32'h1234_5678;
    tick();
    chk1("s_f_rd_en",   mb.bus_rd_en, 1'b1);
    chk ("s_f_addr",    mb.bus_addr, 32'h0000_0200);
    tick();
    chk1("s_if_valid",  mb.if_valid, 1'b1);
    chk ("s_if_rdata",  mb.if_rdata, 32'h1234_5678);
    mb.if_req = 0;
    tick();

    // read+write together behaves as a write, d_rdata untouched
    mb.bus_data_rd = 32'hDEAD_BEEF;
    mb.d_rd_en = 1; mb.d_wr_en = 1; mb.d_addr = 32'h0000_0030;
    mb.d_wrdata = 32'h0000_0055; mb.d_byte_en = 4'hF;
    tick();
    chk1("rw_wr_en", mb.bus_wr_en, 1'b1);
    chk1("rw_rd_en", mb.bus_rd_en, 1'b0);
    chk ("rw_wdata", mb.bus_data_wr, 32'h0000_0055);
    tick();
    chk1("rw_valid", mb.d_valid, 1'b1);
    chk ("rw_rdata", mb.d_rdata, 32'hCAFE_0001);
    mb.d_rd_en = 0; mb.d_wr_en = 0;
    tick();

    // write with three wait states
    mb.bus_ready = 0;
    mb.d_wr_en = 1; mb.d_addr = 32'h2000_0003; mb.d_byte_en = 4'b1000;
    mb.d_wrdata = 32'hAB00_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("w_wr_en", mb.bus_wr_en, 1'b1);
      chk ("w_addr",  mb.bus_addr, 32'h2000_0003);
      chk ("w_data",  mb.bus_data_wr, 32'hAB00_0000);
      chk ("w_be",    {28'h0, mb.bus_byte_en}, 32'h8);
      chk1("w_no_valid", mb.d_valid, 1'b0);
      mb.d_addr = 32'h0;       // mid-transaction changes must be ignored
      mb.d_wrdata = 32'hFFFF_FFFF;
    end
    mb.bus_ready = 1;
    tick();
    chk1("w_valid", mb.d_valid, 1'b1);
    chk1("w_wr_drop", mb.bus_wr_en, 1'b0);
    chk ("w_rdata", mb.d_rdata, 32'hCAFE_0001);
    mb.d_wr_en = 0;
    tick();

    // back-to-back fetches: one access per 3 cycles
    mb.if_req = 1; mb.if_addr = 32'h0000_0300; mb.bus_data_rd = 32'h0000_0013;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (mb.if_valid) n++;
    end
    chk("b2b_pulses", n, 3);
    mb.if_req = 0;
    tick();

    // reset while a data read waits
    mb.bus_ready = 0;
    mb.d_rd_en = 1; mb.d_addr = 32'h0000_0040; mb.d_byte_en = 4'hF;
    tick();
    chk1("r_rd_en", mb.bus_rd_en, 1'b1);
    #2 rst = 0;
    #1;
    chk1("r_rd_async", mb.bus_rd_en, 1'b0);
    chk1("r_wr_async", mb.bus_wr_en, 1'b0);
    mb.d_rd_en = 0;
    tick();
    chk1("r_no_valid", mb.d_valid, 1'b0);
    rst = 1;
    tick();
    chk1("r_no_valid2", mb.d_valid, 1'b0);
    mb.bus_ready = 1; mb.bus_data_rd = 32'h0000_0077;
    mb.d_rd_en = 1; mb.d_addr = 32'h0000_0044;
    tick();
    chk ("r_addr", mb.bus_addr, 32'h0000_0044);
    tick();
    chk1("r_valid", mb.d_valid, 1'b1);
    chk ("r_rdata", mb.d_rdata, 32'h0000_0077);
    mb.d_rd_en = 0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // stuck slave: terminate on the 4th wait cycle
    mb.bus_ready = 0;
    mb.d_rd_en = 1; mb.d_addr = 32'h0000_0050;
    tick();
    chk1("t_rd_en", mb.bus_rd_en, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("t_wait_valid", mb.d_valid, 1'b0);
      chk1("t_wait_rd_en", mb.bus_rd_en, 1'b1);
    end
    tick();
    chk1("t_valid", mb.d_valid, 1'b1);
    chk1("t_err",   mb.bus_err, 1'b1);
    chk ("t_rdata", mb.d_rdata, 32'h0);
    chk1("t_rd_drop", mb.bus_rd_en, 1'b0);
    mb.d_rd_en = 0;
    tick();
    mb.bus_ready = 1; mb.bus_data_rd = 32'h0000_0099; mb.d_rd_en = 1;
    tick();
    tick();
    chk1("t_next_valid", mb.d_valid, 1'b1);
    chk1("t_next_err",   mb.bus_err, 1'b0);
    chk ("t_next_rdata", mb.d_rdata, 32'h0000_0099);
    mb.d_rd_en = 0;
    tick();
`endif

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
